// File: rtl/jt49_noise_rx_if.sv
// Port bundle for the JT49 noise receiver: strobed serial noise in, lock status and
// error statistics out.
interface jt49_noise_rx_if #(
   parameter int ERRW = 8
);
   logic            cen;
   logic            shift;
   logic            noise;
   logic [1:0]      state;
   logic            locked;
   logic            err;
   logic [ERRW-1:0] err_cnt;
   logic [9:0]      interval;

   modport master (
      output cen, shift, noise,
      input  state, locked, err, err_cnt, interval
   );

   modport slave (
      input  cen, shift, noise,
      output state, locked, err, err_cnt, interval
   );
endinterface

// File: rtl/jt49_noise_rx.sv
// Follows the JT49 17-bit noise LFSR from its serial output, predicts each bit,
// and reports lock state, misprediction pulses/counts and the step interval.
//
// state  | meaning
// HUNT   | filling the 17-bit model register, no checking
// VERIFY | checking predictions, LOCKN clean steps in a row needed to lock
// LOCK   | tracking, LOSTN consecutive misses drop back to HUNT
module jt49_noise_rx #(
   parameter int ERRW  = 8,
   parameter int LOCKN = 8,
   parameter int LOSTN = 4
) (
   input  logic           clk,
   input  logic           rst,
   jt49_noise_rx_if.slave bus
);

   localparam int RUNW  = $clog2(LOCKN + 1);
   localparam int MISSW = $clog2(LOSTN + 1);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCK   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [16:0]       r_q, r_d;
   logic [4:0]        fill_q, fill_d;
   logic [RUNW-1:0]   run_q, run_d;
   logic [MISSW-1:0]  miss_q, miss_d;
   logic              err_q, err_d;
   logic [ERRW-1:0]   err_cnt_q, err_cnt_d;
   logic [9:0]        icnt_q, icnt_d;
   logic [9:0]        interval_q, interval_d;

   logic              step;
   logic              pred;
   logic              mismatch;
   logic [RUNW-1:0]   run_inc;
   logic [MISSW-1:0]  miss_inc;
   logic [ERRW-1:0]   err_cnt_inc;
   logic [9:0]        icnt_inc;

   always_comb begin
      step        = bus.cen & bus.shift;
      // The r==0 term mirrors the generator's escape from the all-zero state.
      pred        = r_q[0] ^ r_q[2] ^ (r_q == 17'd0);
      mismatch    = bus.noise ^ pred;
      run_inc     = run_q + 1'b1;
      miss_inc    = miss_q + 1'b1;
      err_cnt_inc = (err_cnt_q == {ERRW{1'b1}}) ? err_cnt_q : err_cnt_q + 1'b1;
      icnt_inc    = (icnt_q == 10'd1023) ? icnt_q : icnt_q + 10'd1;

      state_d     = state_q;
      r_d         = r_q;
      fill_d      = fill_q;
      run_d       = run_q;
      miss_d      = miss_q;
      err_d       = 1'b0;
      err_cnt_d   = err_cnt_q;
      icnt_d      = icnt_q;
      interval_d  = interval_q;

      if (bus.cen) begin
         icnt_d = icnt_inc;
      end

      if (step) begin
         r_d        = {bus.noise, r_q[16:1]};
         interval_d = icnt_inc;
         icnt_d     = 10'd0;
         unique case (state_q)
            ST_HUNT: begin
               if (fill_q == 5'd16) begin
                  state_d = ST_VERIFY;
                  fill_d  = 5'd0;
                  run_d   = '0;
               end else begin
                  fill_d = fill_q + 5'd1;
               end
            end
            ST_VERIFY: begin
               if (mismatch) begin
                  err_d     = 1'b1;
                  err_cnt_d = err_cnt_inc;
                  state_d   = ST_HUNT;
                  fill_d    = 5'd0;
               end else if (run_inc == RUNW'(LOCKN)) begin
                  state_d = ST_LOCK;
                  miss_d  = '0;
               end else begin
                  run_d = run_inc;
               end
            end
            ST_LOCK: begin
               if (mismatch) begin
                  err_d     = 1'b1;
                  err_cnt_d = err_cnt_inc;
                  if (miss_inc == MISSW'(LOSTN)) begin
                     state_d = ST_HUNT;
                     fill_d  = 5'd0;
                  end else begin
                     miss_d = miss_inc;
                  end
               end else begin
                  miss_d = '0;
               end
            end
            default: begin
               state_d = ST_HUNT;
               fill_d  = 5'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_HUNT;
         r_q        <= 17'd0;
         fill_q     <= 5'd0;
         run_q      <= '0;
         miss_q     <= '0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
         icnt_q     <= 10'd0;
         interval_q <= 10'd0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         fill_q     <= fill_d;
         run_q      <= run_d;
         miss_q     <= miss_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
         icnt_q     <= icnt_d;
         interval_q <= interval_d;
      end
   end

   assign bus.state    = state_q;
   assign bus.locked   = (state_q == ST_LOCK);
   assign bus.err      = err_q;
   assign bus.err_cnt  = err_cnt_q;
   assign bus.interval = interval_q;

endmodule

// File: tb/tb_jt49_noise_rx.sv
// Bench for jt49_noise_rx: directed lock/loss scenarios plus random traffic, all
// checked every cycle against a history-based reference model.
module tb_jt49_noise_rx;

   localparam int ERRW   = 8;
   localparam int LOCKN  = 8;
   localparam int LOSTN  = 4;
   localparam int ERRMAX = (1 << ERRW) - 1;
   localparam int HUNT = 0, VERIFY = 1, LOCK = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jt49_noise_rx_if #(.ERRW(ERRW)) bus ();

   jt49_noise_rx #(.ERRW(ERRW), .LOCKN(LOCKN), .LOSTN(LOSTN)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: last 17 accepted bits, oldest at index 0.
   bit hq[$];
   int m_state, m_fill, m_run, m_miss, m_errcnt, m_icnt, m_interval;
   bit m_err;

   function automatic void model_reset();
      m_state = HUNT; m_fill = 0; m_run = 0; m_miss = 0;
      m_errcnt = 0; m_icnt = 0; m_interval = 0; m_err = 0;
      hq.delete();
      for (int i = 0; i < 17; i++) hq.push_back(1'b0);
   endfunction

   function automatic bit m_pred();
      int ones = 0;
      foreach (hq[i]) ones += int'(hq[i]);
      return hq[0] ^ hq[2] ^ (ones == 0);
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic void model_step(input bit c, input bit s, input bit n);
      bit miss_now;
      m_err = 0;
      if (!c) return;
      if (!s) begin
         m_icnt = sat(m_icnt + 1, 1023);
         return;
      end
      miss_now   = (n != m_pred());
      m_interval = sat(m_icnt + 1, 1023);
      m_icnt     = 0;
      if (m_state == HUNT) begin
         m_fill++;
         if (m_fill == 17) begin m_state = VERIFY; m_run = 0; m_fill = 0; end
      end else if (m_state == VERIFY) begin
         if (miss_now) begin
            m_err = 1; m_errcnt = sat(m_errcnt + 1, ERRMAX);
            m_state = HUNT; m_fill = 0;
         end else begin
            m_run++;
            if (m_run == LOCKN) begin m_state = LOCK; m_miss = 0; end
         end
      end else begin
         if (miss_now) begin
            m_err = 1; m_errcnt = sat(m_errcnt + 1, ERRMAX);
            m_miss++;
            if (m_miss == LOSTN) begin m_state = HUNT; m_fill = 0; m_miss = 0; end
         end else begin
            m_miss = 0;
         end
      end
      void'(hq.pop_front());
      hq.push_back(n);
   endfunction

   // Golden noise generator.
   logic [16:0] g = 17'd0;
   function automatic bit gen_bit();
      bit nb;
      nb = g[0] ^ g[2] ^ (g == 17'd0);
      g  = {nb, g[16:1]};
      return nb;
   endfunction

   task automatic compare_all();
      chk("state",    32'(bus.state),    32'(m_state));
      chk("locked",   32'(bus.locked),   32'(m_state == LOCK));
      chk("err",      32'(bus.err),      32'(m_err));
      chk("err_cnt",  32'(bus.err_cnt),  32'(m_errcnt));
      chk("interval", 32'(bus.interval), 32'(m_interval));
   endtask

   task automatic cyc(input logic c, input logic s, input logic n);
      bus.cen = c; bus.shift = s; bus.noise = n;
      @(posedge clk);
      model_step(c, s, n);
      #1;
      compare_all();
   endtask

   task automatic step4(input logic n);
      cyc(1'b1, 1'b1, n);
      repeat (3) cyc(1'b1, 1'b0, 1'($urandom));
   endtask

   task automatic async_reset();
      @(posedge clk);
      #3;
      bus.cen = 1'b1; bus.shift = 1'b1;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_errcnt", 32'(bus.err_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int inj;
      bit n;
      bus.cen = 1'b0; bus.shift = 1'b0; bus.noise = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 32'(bus.state), 32'd0);
      chk("reset_locked", 32'(bus.locked), 32'd0);
      chk("reset_err", 32'(bus.err), 32'd0);
      chk("reset_errcnt", 32'(bus.err_cnt), 32'd0);
      chk("reset_interval", 32'(bus.interval), 32'd0);
      rst = 1'b0;

      // Clean stream from the all-zero generator, one step every 4 cycles.
      for (int k = 1; k <= 40; k++) begin
         step4(gen_bit());
         if (k == 17 || k == 24 || k == 25)
            chk("golden_state", 32'(bus.state), (k < 17) ? 32'd0 : (k < 25) ? 32'd1 : 32'd2);
      end
      chk("golden_locked", 32'(bus.locked), 32'd1);
      chk("golden_errcnt", 32'(bus.err_cnt), 32'd0);
      chk("golden_interval", 32'(bus.interval), 32'd4);

      // Single inversion while locked, then four in a row.
      cyc(1'b1, 1'b1, ~gen_bit());
      chk("lock1_err", 32'(bus.err), 32'd1);
      chk("lock1_errcnt", 32'(bus.err_cnt), 32'd1);
      chk("lock1_locked", 32'(bus.locked), 32'd1);
      cyc(1'b1, 1'b0, 1'b0);
      chk("lock1_err_drop", 32'(bus.err), 32'd0);
      repeat (2) cyc(1'b1, 1'b1, gen_bit());
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 1'b1, ~gen_bit());
         chk("lock4_err", 32'(bus.err), 32'd1);
      end
      chk("lock4_state", 32'(bus.state), 32'd0);
      chk("lock4_errcnt", 32'(bus.err_cnt), 32'd5);

      // Mismatch during VERIFY, then relock after 25 clean steps.
      repeat (17) cyc(1'b1, 1'b1, gen_bit());
      chk("ver_entry", 32'(bus.state), 32'd1);
      repeat (2) cyc(1'b1, 1'b1, gen_bit());
      cyc(1'b1, 1'b1, ~gen_bit());
      chk("ver_err", 32'(bus.err), 32'd1);
      chk("ver_state", 32'(bus.state), 32'd0);
      chk("ver_errcnt", 32'(bus.err_cnt), 32'd6);
      repeat (24) cyc(1'b1, 1'b1, gen_bit());
      chk("ver_relock_24", 32'(bus.locked), 32'd0);
      cyc(1'b1, 1'b1, gen_bit());
      chk("ver_relock_25", 32'(bus.locked), 32'd1);

      // Asynchronous reset while locked, then full relock.
      async_reset();
      repeat (24) cyc(1'b1, 1'b1, gen_bit());
      chk("rst_relock_24", 32'(bus.locked), 32'd0);
      cyc(1'b1, 1'b1, gen_bit());
      chk("rst_relock_25", 32'(bus.locked), 32'd1);

      // Random traffic with occasional bit flips.
      for (int k = 0; k < 3000; k++) begin
         logic c, s, nb;
         c  = ($urandom_range(0, 3) != 0);
         s  = 1'($urandom);
         nb = 1'($urandom);
         if (c && s) nb = gen_bit() ^ ($urandom_range(0, 31) == 0);
         cyc(c, s, nb);
      end

      // All-zero stream: prediction becomes 1 once r is zero after fill.
      async_reset();
      repeat (17) cyc(1'b1, 1'b1, 1'b0);
      chk("zero_state", 32'(bus.state), 32'd1);
      cyc(1'b1, 1'b1, 1'b0);
      chk("zero_err", 32'(bus.err), 32'd1);
      chk("zero_errcnt", 32'(bus.err_cnt), 32'd1);

      // cen low ignores shift; long gap saturates interval.
      repeat (2000) cyc(1'b0, 1'b1, 1'($urandom));
      chk("cen_off_state", 32'(bus.state), 32'd0);
      repeat (2000) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      chk("interval_sat", 32'(bus.interval), 32'd1023);

      // Drive enough mispredictions to saturate err_cnt.
      inj = 0;
      for (int k = 0; k < 20000 && inj < 300; k++) begin
         if (m_state != HUNT) begin
            n = !m_pred();
            inj++;
         end else begin
            n = 1'($urandom);
         end
         cyc(1'b1, 1'b1, n);
      end
      chk("inject_budget", 32'(inj), 32'd300);
      chk("errcnt_sat", 32'(bus.err_cnt), 32'(ERRMAX));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/jt49_noise_rx.md
JT49_NOISE_RX -- requirements
Module: jt49_noise_rx

Interface
REQ-001 Parameter: ERRW, default 8, width of the saturating error counter.
REQ-002 Parameter: LOCKN, default 8, consecutive correct predictions required in VERIFY before LOCK.
REQ-003 Parameter: LOSTN, default 4, consecutive mispredictions in LOCK that force HUNT.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cen  input  1  clock enable; nothing but reset changes state when low.
REQ-007 shift  input  1  strobe, one cycle per generator LFSR step; honoured only with cen=1.
REQ-008 noise  input  1  serial noise bit from the 17-bit generator, valid when shift=1.
REQ-009 state  output  2  0=HUNT, 1=VERIFY, 2=LOCK; 3 is never produced.
REQ-010 locked  output  1  high when state=LOCK.
REQ-011 err  output  1  one-cycle pulse on each misprediction in VERIFY or LOCK.
REQ-012 err_cnt  output  ERRW  saturating misprediction count since reset.
REQ-013 interval  output  10  cen-qualified cycles between the last two accepted shift strobes, saturating at 1023.

Function
REQ-014 Accepted step = cen & shift; all rules below act only on accepted steps unless stated otherwise.
REQ-015 A 17-bit register r models the generator state; on every accepted step, r <= {noise, r[16:1]} in all states.
REQ-016 Predicted bit = r[0] ^ r[2] ^ (r==0), computed from r before the step.
REQ-017 HUNT: 5-bit fill counter increments per step; after the 17th step, go to VERIFY with the run counter cleared; no prediction checking and no err in HUNT.
REQ-018 VERIFY: match increments run; run reaching LOCKN goes to LOCK; a mismatch pulses err, increments err_cnt, returns to HUNT with fill cleared (r still shifts).
REQ-019 LOCK: match clears miss counter; a mismatch pulses err, increments err_cnt and the miss counter; miss counter reaching LOSTN goes to HUNT with fill cleared.
REQ-020 err asserts the cycle after the mismatching step and deasserts the following cycle; back-to-back mismatching steps give back-to-back pulses.
REQ-021 err_cnt saturates at 2^ERRW-1 and never wraps.
REQ-022 Interval counter increments on each cycle with cen=1 and saturates at 1023; on an accepted step, interval <= counter value + 1 (saturated) and the counter clears to 0.
REQ-023 State transitions, err, err_cnt and interval all update on the same edge as the accepted step; latency from shift to updated outputs is one clock.
REQ-024 shift with cen=0 is ignored entirely, including by the interval logic.

Reset
REQ-025 While rst is high: r=0, state=HUNT, fill=0, run=0, miss=0, err=0, err_cnt=0, interval=0, interval counter=0, locked=0.
REQ-026 Reset asserted mid-operation takes effect immediately (asynchronous), regardless of cen; the first accepted step after release is treated as fill step 1.

Verification
REQ-027 Golden generator model from the all-zero state, cen=1, shift every 4 cycles, 40 steps -> state HUNT for steps 1-17, VERIFY 18-25, locked=1 after step 25, err_cnt=0, interval=4.
REQ-028 Locked, invert noise on one step -> single err pulse, err_cnt=1, locked stays 1; invert on 4 consecutive steps -> state=HUNT after the 4th, err_cnt=5.
REQ-029 In VERIFY (step 20), invert one bit -> err pulse, state=HUNT, err_cnt=1; clean stream continued -> locked again 25 steps later.
REQ-030 Hold noise constant 0 from reset for 17 steps (r=0) then feed 0 -> mismatch, since prediction is 1 (zero-lock escape) -> err=1.
REQ-031 Toggle cen low for 2000 cycles with shift high -> no state change; then shift after 2000 cen cycles -> interval=1023; 300 injected errors -> err_cnt=255 (ERRW=8).
REQ-032 Assert rst for one cycle while locked with err_cnt=3 -> all outputs reset immediately; relock requires full 25 clean steps.
